crop_window_scheduler: RTL and testbench

//   Runtime-programmable crop controller for the streamed-image path. Accepts crop

---
 rtl/crop_window_scheduler.sv | 158 +++++++++++++++
 tb/tb_crop_window_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_window_scheduler.sv
// rtl/crop_window_scheduler.sv - per-command crop of one raster frame to a fixed-size window
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   cmd_y1/cmd_x1/cmd_valid/cmd_ready   crop origin command handshake
//   pixel_in/in_valid/in_ready          raster pixel input stream
//   pixel_out/out_valid/out_ready/out_last   registered cropped pixel output
//   crop_done/crop_err         one-cycle frame-complete pulses (legal / illegal origin)
//   crop_count                 legal crops completed since reset, wrapping
module crop_window_scheduler #(
   parameter int PIXEL_BIT_WIDTH = 8,
   parameter int IN_ROWS         = 9,
   parameter int IN_COLS         = 9,
   parameter int OUT_ROWS        = 3,
   parameter int OUT_COLS        = 3,
   parameter int CNT_WIDTH       = 16,
   localparam int YW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1,
   localparam int XW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [YW-1:0]              cmd_y1,
   input  logic [XW-1:0]              cmd_x1,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic                       crop_done,
   output logic                       crop_err,
   output logic [CNT_WIDTH-1:0]       crop_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [YW-1:0] ROW_LAST = YW'(IN_ROWS - 1);
   localparam logic [XW-1:0] COL_LAST = XW'(IN_COLS - 1);
   localparam int            Y_MAX    = IN_ROWS - OUT_ROWS;
   localparam int            X_MAX    = IN_COLS - OUT_COLS;

   state_t        state, state_next;
   logic [YW-1:0] row, y1;
   logic [XW-1:0] col, x1;
   logic          err;
   logic          cmd_fire, pix_fire;
   logic          keep, win_last;

   assign cmd_fire = cmd_valid & cmd_ready;
   assign pix_fire = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake outputs are gated by reset so nothing is accepted in the reset cycle,
   // whatever state the register still holds.
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      in_ready   = 1'b0;
      crop_done  = 1'b0;
      crop_err   = 1'b0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  state_next = ST_RUN;
               end
            end
            ST_RUN: begin
               // Back-pressure applies to every pixel, dropped ones included,
               // so the frame position never runs ahead of the output stage.
               in_ready = !out_valid || out_ready;
               if (in_valid && in_ready && row == ROW_LAST && col == COL_LAST) begin
                  state_next = ST_DONE;
               end
            end
            ST_DONE: begin
               crop_done  = !err;
               crop_err   = err;
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Command latch and raster position counters
   always_ff @(posedge clk) begin
      if (reset) begin
         row <= '0;
         col <= '0;
         y1  <= '0;
         x1  <= '0;
         err <= 1'b0;
      end else if (cmd_fire) begin
         y1  <= cmd_y1;
         x1  <= cmd_x1;
         err <= (int'(cmd_y1) > Y_MAX) || (int'(cmd_x1) > X_MAX);
         row <= '0;
         col <= '0;
      end else if (pix_fire) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Window test done in int so y1+OUT_ROWS-1 cannot overflow the counter width
   always_comb begin
      keep     = !err
                 && int'(row) >= int'(y1) && int'(row) <= int'(y1) + OUT_ROWS - 1
                 && int'(col) >= int'(x1) && int'(col) <= int'(x1) + OUT_COLS - 1;
      win_last = int'(row) == int'(y1) + OUT_ROWS - 1
                 && int'(col) == int'(x1) + OUT_COLS - 1;
   end

   // Output register runs independently of the FSM so a last word can drain
   // while the next command is already being accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_out <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (pix_fire && keep) begin
         pixel_out <= pixel_in;
         out_valid <= 1'b1;
         out_last  <= win_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crop_count <= '0;
      end else if (state == ST_DONE && !err) begin
         crop_count <= crop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_crop_window_scheduler.sv
// tb/tb_crop_window_scheduler.sv - randomized self-checking bench for crop_window_scheduler
module tb_crop_window_scheduler;

   localparam int PW  = 8;
   localparam int IR  = 9;
   localparam int IC  = 9;
   localparam int OR_ = 3;
   localparam int OC  = 3;
   localparam int CW  = 16;
   localparam int YW  = $clog2(IR);
   localparam int XW  = $clog2(IC);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [YW-1:0] cmd_y1 = '0;
   logic [XW-1:0] cmd_x1 = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [PW-1:0] pixel_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] pixel_out;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic          crop_done;
   logic          crop_err;
   logic [CW-1:0] crop_count;

   crop_window_scheduler #(
      .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IR), .IN_COLS(IC),
      .OUT_ROWS(OR_), .OUT_COLS(OC), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_y1(cmd_y1), .cmd_x1(cmd_x1), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
      .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .crop_done(crop_done), .crop_err(crop_err), .crop_count(crop_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PW-1:0] pix;
      logic          last;
   } exp_t;

   exp_t exp_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;
   int   done_seen = 0, err_seen = 0;
   int   exp_done  = 0, exp_err  = 0, exp_count = 0;
   int   ready_mode = 0;   // 0 always ready, 1 random, 2 held low

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   always begin
      @(posedge clk);
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // Scoreboard: a transfer seen here completes on the following rising edge
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (crop_done) done_seen++;
         if (crop_err)  err_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_value("out_without_expected", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check_value("pixel_out", pixel_out, e.pix);
               check_value("out_last", out_last, e.last);
            end
         end
      end
   end

   // Reference: the window is the rectangle of raster indices starting at (y,x)
   task automatic expect_crop(input int y, input int x, input int base);
      if (y <= IR - OR_ && x <= IC - OC) begin
         for (int r = y; r < y + OR_; r++) begin
            for (int c = x; c < x + OC; c++) begin
               exp_t e;
               e.pix  = PW'(base + r * IC + c);
               e.last = (r == y + OR_ - 1) && (c == x + OC - 1);
               exp_q.push_back(e);
            end
         end
         exp_done++;
         exp_count = (exp_count + 1) % (1 << CW);
      end else begin
         exp_err++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_value({tag, "_out_valid"}, out_valid, 0);
      check_value({tag, "_out_last"}, out_last, 0);
      check_value({tag, "_pixel_out"}, pixel_out, 0);
      check_value({tag, "_crop_count"}, crop_count, 0);
      check_value({tag, "_cmd_ready"}, cmd_ready, 0);
      check_value({tag, "_in_ready"}, in_ready, 0);
      check_value({tag, "_crop_done"}, crop_done, 0);
      check_value({tag, "_crop_err"}, crop_err, 0);
   endtask

   task automatic send_cmd(input int y, input int x);
      int guard = 0;
      bit ok;
      cmd_y1    = YW'(y);
      cmd_x1    = XW'(x);
      cmd_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!ok && guard < 50);
      cmd_valid = 1'b0;
      check_value("cmd_accept", ok, 1);
   endtask

   task automatic mid_frame_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      cmd_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_value("rst_cycle_cmd_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_values("midrst");
      @(posedge clk);
      #1;
      reset     = 1'b0;
      exp_count = 0;
      exp_done  = 0;
      exp_err   = 0;
      done_seen = 0;
      err_seen  = 0;
   endtask

   task automatic send_frame(input int base, input bit rnd, input int stall_at, input int abort_at);
      int beat = 0;
      int guard = 0;
      bit ok;
      while (beat < IR * IC && guard < 5000) begin
         if (beat == abort_at) begin
            mid_frame_reset();
            return;
         end
         if (beat == stall_at) begin
            int saved = ready_mode;
            ready_mode = 2;
            in_valid   = 1'b1;
            pixel_in   = PW'(base + beat);
            repeat (20) begin
               @(negedge clk);
               check_value("stall_in_ready", in_ready, 0);
               check_value("stall_out_valid", out_valid, 1);
               check_value("stall_pixel_out", pixel_out, PW'(base + beat - 1));
               @(posedge clk);
               #1;
            end
            ready_mode = saved;
            stall_at   = -1;
         end
         in_valid = rnd ? ($urandom_range(0, 15) != 0) : 1'b1;
         pixel_in = PW'(base + beat);
         @(negedge clk);
         ok = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (ok) beat++;
         guard++;
      end
      in_valid = 1'b0;
      check_value("frame_beats", beat, IR * IC);
   endtask

   task automatic run_crop(input int y, input int x, input int base, input bit rnd,
                           input int stall_at, input int abort_at);
      send_cmd(y, x);
      expect_crop(y, x, base);
      send_frame(base, rnd, stall_at, abort_at);
   endtask

   task automatic settle(input string tag);
      ready_mode = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check_value({tag, "_crop_count"}, crop_count, exp_count);
      check_value({tag, "_done_pulses"}, done_seen, exp_done);
      check_value({tag, "_err_pulses"}, err_seen, exp_err);
      check_value({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_crop(2, 2, 0, 1'b0, -1, -1);
      settle("t1_center");

      run_crop(6, 6, 0, 1'b0, -1, -1);
      run_crop(0, 0, 0, 1'b0, -1, -1);
      settle("t2_corners");

      run_crop(7, 0, 0, 1'b0, -1, -1);
      settle("t3_illegal_y");
      run_crop(0, 7, 0, 1'b0, -1, -1);
      settle("t3_illegal_x");

      run_crop(2, 2, 0, 1'b0, 22, -1);
      settle("t4_stall");

      ready_mode = 1;
      for (int i = 0; i < 400; i++) begin
         run_crop(2, 2, int'($urandom_range(0, 255)), 1'b1, -1, -1);
      end
      settle("t5_random");

      ready_mode = 1;
      for (int i = 0; i < 60; i++) begin
         run_crop(int'($urandom_range(0, 15)) % (1 << YW), int'($urandom_range(0, 15)) % (1 << XW),
                  int'($urandom_range(0, 255)), 1'b1, -1, -1);
      end
      settle("t7_rand_origin");

      run_crop(2, 2, 0, 1'b0, -1, 40);
      run_crop(2, 2, 0, 1'b0, -1, -1);
      settle("t6_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
